// File: rtl/lvds_word_aligner.sv
// Comma-based word aligner between the LVDS deserializer and the 8b/10b decoder.
// It searches all ten bit offsets for K28.5, locks, and drops lock on foreign commas or decoder errors.
module lvds_word_aligner #(
  parameter int LOCK_CNT  = 4,
  parameter int LOSS_CNT  = 4,
  parameter int ERR_LIMIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] raw_data,
  input  logic       raw_valid,
  input  logic       dec_err,
  output logic [9:0] aligned_data,
  output logic       out_valid,
  output logic       comma,
  output logic       locked,
  output logic [3:0] offset,
  output logic [7:0] relock_cnt
);

  typedef enum logic [1:0] {UNLOCKED, CHECK, LOCKED} state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_CNT);
  localparam logic [7:0] ERR_N  = 8'(ERR_LIMIT);

  state_t      state_reg, state_next;
  logic [9:0]  prev_reg;
  logic [3:0]  offset_reg, offset_next;
  logic [3:0]  cnt_reg, cnt_next, cnt_inc;
  logic [7:0]  ecnt_reg, ecnt_next, ecnt_inc;
  logic [7:0]  relock_next;

  logic [19:0] window;
  logic [9:0]  cand [10];
  logic [9:0]  match;
  logic        hit;
  logic [3:0]  hit_off;
  logic        aligned_hit;
  logic        err_evt;

  assign window = {raw_data, prev_reg};

  generate
    for (genvar gi = 0; gi < 10; gi++) begin : g_cand
      assign cand[gi]  = window[gi+9:gi];
      assign match[gi] = (cand[gi] == 10'h17C) || (cand[gi] == 10'h283);
    end
  endgenerate

  assign hit = |match;

  // Lowest matching offset wins when several candidates match.
  always_comb begin
    hit_off = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      if (match[i]) hit_off = 4'(i);
    end
  end

  assign aligned_hit = match[offset_reg];
  // out_valid high now means the decoder's flag refers to the word we are presenting.
  assign err_evt     = dec_err && out_valid && (state_reg == LOCKED);
  assign cnt_inc     = cnt_reg + 4'd1;
  assign ecnt_inc    = ecnt_reg + 8'd1;

  always_comb begin
    state_next  = state_reg;
    offset_next = offset_reg;
    cnt_next    = cnt_reg;
    ecnt_next   = ecnt_reg;
    relock_next = relock_cnt;
    if (raw_valid) begin
      case (state_reg)
        UNLOCKED: begin
          if (hit) begin
            offset_next = hit_off;
            if (LOCK_CNT == 1) begin
              state_next = LOCKED;
              cnt_next   = 4'd0;
              ecnt_next  = 8'd0;
            end else begin
              state_next = CHECK;
              cnt_next   = 4'd1;
            end
          end
        end
        CHECK: begin
          if (aligned_hit) begin
            cnt_next = cnt_inc;
            if (cnt_inc == LOCK_N) begin
              state_next = LOCKED;
              cnt_next   = 4'd0;
              ecnt_next  = 8'd0;
            end
          end else if (hit) begin
            offset_next = hit_off;
            cnt_next    = 4'd1;
          end
        end
        LOCKED: begin
          // An aligned comma clears both counters, even alongside a decoder error.
          if (aligned_hit) begin
            cnt_next  = 4'd0;
            ecnt_next = 8'd0;
          end else begin
            if (hit)     cnt_next  = cnt_inc;
            if (err_evt) ecnt_next = ecnt_inc;
            if ((hit && cnt_inc == LOSS_N) || (err_evt && ecnt_inc == ERR_N)) begin
              state_next = UNLOCKED;
              cnt_next   = 4'd0;
              ecnt_next  = 8'd0;
              if (relock_cnt != 8'hFF) relock_next = relock_cnt + 8'd1;
            end
          end
        end
        default: state_next = UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= UNLOCKED;
      prev_reg     <= '0;
      offset_reg   <= '0;
      cnt_reg      <= '0;
      ecnt_reg     <= '0;
      relock_cnt   <= '0;
      aligned_data <= '0;
      comma        <= 1'b0;
      out_valid    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      offset_reg <= offset_next;
      cnt_reg    <= cnt_next;
      ecnt_reg   <= ecnt_next;
      relock_cnt <= relock_next;
      out_valid  <= raw_valid && (state_reg == LOCKED);
      if (raw_valid) begin
        prev_reg     <= raw_data;
        aligned_data <= cand[offset_reg];
        comma        <= match[offset_reg];
      end
    end
  end

  assign locked = (state_reg == LOCKED);
  assign offset = offset_reg;

endmodule
